// File: rtl/main_memory_responder.sv
// rtl/main_memory_responder.sv - main-memory responder with fixed read latency and 1-deep pending read slot
module main_memory_responder #(
    parameter int CORES     = 32,
    parameter int BITS      = 16,
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_ctrl,
    input  logic [15:0]             load_addr,
    input  logic                    write_ctrl,
    input  logic [15:0]             write_addr_main,
    input  logic [CORES*BITS-1:0]   write_data_main,
    output logic [CORES*BITS-1:0]   load_data,
    output logic                    load_valid,
    output logic                    busy
);

    localparam int W     = CORES * BITS;
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                 state, state_next;
    logic [3:0]             cnt, cnt_next;
    logic [ADDR_BITS-1:0]   cap_addr, cap_next;
    logic                   pend_valid, pend_valid_next;
    logic [ADDR_BITS-1:0]   pend_addr, pend_addr_next;
    logic                   prev_ctrl;
    logic [15:0]            prev_addr;
    logic                   new_event;
    logic                   read_fire;
    logic [ADDR_BITS-1:0]   rd_idx, wr_idx;
    logic [W-1:0]           read_word;
    logic                   unused_addr_hi;

    logic [W-1:0] mem [0:DEPTH-1];

    // Upper address bits are deliberately ignored so addresses wrap modulo depth.
    assign rd_idx         = load_addr[ADDR_BITS-1:0];
    assign wr_idx         = write_addr_main[ADDR_BITS-1:0];
    assign unused_addr_hi = ^write_addr_main;

    // A held request level is served once; a new address under the same level is a new request.
    assign new_event = load_ctrl && (!prev_ctrl || (load_addr != prev_addr));

    // Same-cycle write to the word being read wins over the stored contents.
    assign read_word = (write_ctrl && (wr_idx == cap_addr)) ? write_data_main : mem[cap_addr];

    // Next-state logic: accept from pending slot first, count down latency, then respond.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        cap_next        = cap_addr;
        pend_valid_next = pend_valid;
        pend_addr_next  = pend_addr;
        read_fire       = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend_valid) begin
                    cap_next   = pend_addr;
                    cnt_next   = CNT_INIT;
                    state_next = S_WAIT;
                    if (new_event) begin
                        pend_addr_next = rd_idx;
                    end else begin
                        pend_valid_next = 1'b0;
                    end
                end else if (new_event) begin
                    cap_next   = rd_idx;
                    cnt_next   = CNT_INIT;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    read_fire  = 1'b1;
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
                if (new_event) begin
                    pend_valid_next = 1'b1;
                    pend_addr_next  = rd_idx;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
                if (new_event) begin
                    pend_valid_next = 1'b1;
                    pend_addr_next  = rd_idx;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Control and response registers; reset abandons any in-flight read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            cap_addr   <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            prev_ctrl  <= 1'b0;
            prev_addr  <= 16'd0;
            load_data  <= '0;
            load_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            cap_addr   <= cap_next;
            pend_valid <= pend_valid_next;
            pend_addr  <= pend_addr_next;
            prev_ctrl  <= load_ctrl;
            prev_addr  <= load_addr;
            if (read_fire) begin
                load_data <= read_word;
            end
            load_valid <= read_fire;
            busy       <= (state_next != S_IDLE);
        end
    end

    // Storage array: writes are never stalled and the contents survive reset.
    always_ff @(posedge clock) begin
        if (write_ctrl) begin
            mem[wr_idx] <= write_data_main;
        end
    end

endmodule
